// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw switches and hold come in, and clean levels and change pulses go out.
// The master drives the raw side. The slave is the debouncer.
interface sw_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic             hold;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] chg_mask;
  logic             sw_chg;

  modport master (
    output sw_raw,
    output hold,
    input  sw_db,
    input  chg_mask,
    input  sw_chg
  );

  modport slave (
    input  sw_raw,
    input  hold,
    output sw_db,
    output chg_mask,
    output sw_chg
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: a 2-flop synchroniser feeds an independent stable-time counter.
// The block also emits a registered one-cycle change pulse for each committed bit.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  sw
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             any_chg_q, any_chg_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // Sync stage: s1 -> s2 is a bare flop pair, so nothing may sit between them.
  always_comb begin
    s1_d = sw.sw_raw;
    s2_d = s1_q;
  end

  // Debounce stage: hold beats everything, and a bounce back to sw_db restarts timing.
  always_comb begin
    db_d  = db_q;
    chg_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sw.hold) begin
        cnt_d[i] = '0;
      end else if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        chg_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_inc(cnt_q[i]);
      end
    end
    any_chg_d = |chg_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      chg_q     <= '0;
      any_chg_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      chg_q     <= chg_d;
      any_chg_q <= any_chg_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw.sw_db    = db_q;
  assign sw.chg_mask = chg_q;
  assign sw.sw_chg   = any_chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4, CNT_W=3 and WIDTH=8.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_sw_debounce;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sw_debounce_if #(.WIDTH(8)) bus ();

  sw_debounce #(
    .WIDTH(8),
    .CNT_W(3),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    bus.hold = 1'b0;
    bus.sw_raw = 8'hFF;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.sw_db !== 8'h00) begin
        miscompares++; $display("FAIL reset_sw_db edge%0d got %h want 00", e, bus.sw_db);
      end
      vectors++;
      if (bus.chg_mask !== 8'h00) begin
        miscompares++; $display("FAIL reset_chg_mask edge%0d got %h want 00", e, bus.chg_mask);
      end
      vectors++;
      if (bus.sw_chg !== 1'b0) begin
        miscompares++; $display("FAIL reset_sw_chg edge%0d got %b want 0", e, bus.sw_chg);
      end
    end
  endtask

  task automatic test_startup();
    logic [7:0] exp_db, exp_chg;
    @(negedge clk);
    bus.sw_raw = 8'h05;
    rst = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk); #1;
      exp_db  = (e >= 5) ? 8'h05 : 8'h00;
      exp_chg = (e == 5) ? 8'h05 : 8'h00;
      vectors++;
      if (bus.sw_db !== exp_db) begin
        miscompares++; $display("FAIL startup_sw_db E+%0d got %h want %h", e, bus.sw_db, exp_db);
      end
      vectors++;
      if (bus.chg_mask !== exp_chg) begin
        miscompares++; $display("FAIL startup_chg_mask E+%0d got %h want %h", e, bus.chg_mask, exp_chg);
      end
      vectors++;
      if (bus.sw_chg !== (e == 5)) begin
        miscompares++; $display("FAIL startup_sw_chg E+%0d got %b want %b", e, bus.sw_chg, (e == 5));
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    bus.sw_raw = 8'h04;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.sw_db !== 8'h05) begin
        miscompares++; $display("FAIL glitch_sw_db E+%0d got %h want 05", e, bus.sw_db);
      end
      vectors++;
      if (bus.chg_mask !== 8'h00 || bus.sw_chg !== 1'b0) begin
        miscompares++; $display("FAIL glitch_pulse E+%0d got %h/%b want 00/0", e, bus.chg_mask, bus.sw_chg);
      end
      if (e == 2) begin
        @(negedge clk);
        bus.sw_raw = 8'h05;
      end
    end
  endtask

  task automatic test_long_low();
    logic [7:0] exp_db, exp_chg;
    @(negedge clk);
    bus.sw_raw = 8'h04;
    for (int e = 0; e <= 9; e++) begin
      @(posedge clk); #1;
      exp_db  = (e >= 5 && e <= 8) ? 8'h04 : 8'h05;
      exp_chg = (e == 5 || e == 9) ? 8'h01 : 8'h00;
      vectors++;
      if (bus.sw_db !== exp_db) begin
        miscompares++; $display("FAIL long_low_sw_db E+%0d got %h want %h", e, bus.sw_db, exp_db);
      end
      vectors++;
      if (bus.chg_mask !== exp_chg) begin
        miscompares++; $display("FAIL long_low_chg_mask E+%0d got %h want %h", e, bus.chg_mask, exp_chg);
      end
      vectors++;
      if (bus.sw_chg !== (exp_chg != 8'h00)) begin
        miscompares++; $display("FAIL long_low_sw_chg E+%0d got %b want %b", e, bus.sw_chg, (exp_chg != 8'h00));
      end
      if (e == 3) begin
        @(negedge clk);
        bus.sw_raw = 8'h05;
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp_db, exp_chg;
    @(negedge clk);
    bus.hold = 1'b1;
    bus.sw_raw = 8'hA0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.sw_db !== 8'h05 || bus.chg_mask !== 8'h00 || bus.sw_chg !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_frozen cyc%0d got %h/%h/%b want 05/00/0", e, bus.sw_db, bus.chg_mask, bus.sw_chg);
      end
    end
    @(negedge clk);
    bus.hold = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk); #1;
      exp_db  = (e >= 3) ? 8'hA0 : 8'h05;
      exp_chg = (e == 3) ? 8'hA5 : 8'h00;
      vectors++;
      if (bus.sw_db !== exp_db) begin
        miscompares++; $display("FAIL unhold_sw_db F+%0d got %h want %h", e, bus.sw_db, exp_db);
      end
      vectors++;
      if (bus.chg_mask !== exp_chg || bus.sw_chg !== (e == 3)) begin
        miscompares++; $display("FAIL unhold_pulse F+%0d got %h/%b want %h/%b", e, bus.chg_mask, bus.sw_chg, exp_chg, (e == 3));
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [7:0] exp_db, exp_chg;
    @(negedge clk);
    bus.sw_raw = 8'hA8;
    for (int e = 0; e <= 3; e++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.sw_db !== 8'hA0 || bus.chg_mask !== 8'h00) begin
        miscompares++; $display("FAIL midcount_pre E+%0d got %h/%h want A0/00", e, bus.sw_db, bus.chg_mask);
      end
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.sw_db !== 8'h00 || bus.chg_mask !== 8'h00 || bus.sw_chg !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got %h/%h/%b want 00/00/0", bus.sw_db, bus.chg_mask, bus.sw_chg);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk); #1;
      exp_db  = (e >= 5) ? 8'hA8 : 8'h00;
      exp_chg = (e == 5) ? 8'hA8 : 8'h00;
      vectors++;
      if (bus.sw_db !== exp_db) begin
        miscompares++; $display("FAIL rerun_sw_db R+%0d got %h want %h", e, bus.sw_db, exp_db);
      end
      vectors++;
      if (bus.chg_mask !== exp_chg || bus.sw_chg !== (e == 5)) begin
        miscompares++; $display("FAIL rerun_pulse R+%0d got %h/%b want %h/%b", e, bus.chg_mask, bus.sw_chg, exp_chg, (e == 5));
      end
    end
  endtask

  task automatic test_mux_hookup();
    logic [1:0] sel;
    logic [1:0] mux_out;
    @(negedge clk);
    bus.sw_raw = 8'b000011_10;
    for (int e = 0; e <= 5; e++) begin
      @(posedge clk); #1;
      if (e < 5) begin
        vectors++;
        if (bus.sw_db !== 8'hA8) begin
          miscompares++; $display("FAIL mux_settle_sw_db E+%0d got %h want a8", e, bus.sw_db);
        end
      end
    end
    vectors++;
    if (bus.sw_db !== 8'h0E) begin
      miscompares++; $display("FAIL mux_sw_db got %h want 0e", bus.sw_db);
    end
    vectors++;
    if (bus.chg_mask !== 8'hA6 || bus.sw_chg !== 1'b1) begin
      miscompares++; $display("FAIL mux_pulse got %h/%b want a6/1", bus.chg_mask, bus.sw_chg);
    end
    sel     = bus.sw_db[1:0];
    mux_out = bus.sw_db[5:4];
    vectors++;
    if (sel !== 2'b10) begin
      miscompares++; $display("FAIL mux_sel got %b want 10", sel);
    end
    vectors++;
    if (mux_out !== 2'b00) begin
      miscompares++; $display("FAIL mux_out got %b want 00", mux_out);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_startup();
    test_glitch();
    test_long_low();
    test_hold();
    test_reset_midcount();
    test_mux_hookup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
